// File: rtl/memarb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Holds the FSM state encoding, the window bounds and the port-id type.
package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] ADDR_LO_DEFAULT = 32'h0000_0C00;
  localparam logic [31:0] ADDR_HI_DEFAULT = 32'h0000_0CFF;

  typedef logic port_id_t;

  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/memarb_pick.sv
// Winner selection between the two request ports.
// Fixed priority (port 0) by default; round-robin when MEMARB_RR_EN is defined.
module memarb_pick
  import memarb_pkg::*;
(
`ifdef MEMARB_RR_EN
  input  logic     i_clk,
  input  logic     i_reset,
  input  logic     i_advance,
`endif
  input  logic     i_req0,
  input  logic     i_req1,
  output logic     o_any,
  output port_id_t o_winner
);

  assign o_any = i_req0 | i_req1;

`ifdef MEMARB_RR_EN
  port_id_t last_port;

  // Reset to port 1 as last winner so port 0 wins the first contention.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      last_port <= 1'b1;
    end else if (i_advance) begin
      last_port <= o_winner;
    end
  end

  always_comb begin
    if (i_req0 && i_req1) begin
      o_winner = ~last_port;
    end else begin
      o_winner = port_id_t'(!i_req0);
    end
  end
`else
  assign o_winner = port_id_t'(!i_req0);
`endif

endmodule

// File: rtl/mem_data_arbiter.sv
// Two-port arbiter/sequencer for the shared data memory window.
// Arbitration mode selected by MEMARB_RR_EN (round-robin) or fixed priority when undefined.
module mem_data_arbiter
  import memarb_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = ADDR_LO_DEFAULT,
  parameter logic [31:0] ADDR_HI = ADDR_HI_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_rsp_valid0,
  output logic        o_rsp_valid1,
  output logic        o_rsp_err,
  output logic [31:0] o_rsp_rdata,
  output logic        o_mem_write,
  output logic        o_mem_read,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  state_t      state, state_nxt;
  logic        any_req;
  logic        take;
  port_id_t    winner;
  logic        sel_we;
  logic        sel_ok;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        lat_we;
  logic        lat_ok;
  port_id_t    lat_port;

  memarb_pick u_pick (
`ifdef MEMARB_RR_EN
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_advance (take),
`endif
    .i_req0    (i_req0),
    .i_req1    (i_req1),
    .o_any     (any_req),
    .o_winner  (winner)
  );

  // Grant is only possible in IDLE and is held off while reset is asserted.
  assign take   = (state == IDLE) && any_req && !i_reset;
  assign o_gnt0 = take && (winner == 1'b0);
  assign o_gnt1 = take && (winner == 1'b1);

  always_comb begin
    sel_we    = i_we0;
    sel_addr  = i_addr0;
    sel_wdata = i_wdata0;
    if (winner == 1'b1) begin
      sel_we    = i_we1;
      sel_addr  = i_addr1;
      sel_wdata = i_wdata1;
    end
    sel_ok = addr_in_window(sel_addr, ADDR_LO, ADDR_HI);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lat_we   <= 1'b0;
      lat_ok   <= 1'b0;
      lat_port <= 1'b0;
    end else if (take) begin
      lat_we   <= sel_we;
      lat_ok   <= sel_ok;
      lat_port <= winner;
    end
  end

  // Memory controls are loaded on the grant edge so they are live for the ACCESS cycle only;
  // the address/data registers double as the payload latch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_mem_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_rsp_valid0 <= 1'b0;
      o_rsp_valid1 <= 1'b0;
      o_rsp_err    <= 1'b0;
      o_rsp_rdata  <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_mem_write  <= take && sel_ok && sel_we;
      o_mem_read   <= take && sel_ok && !sel_we;
      o_mem_addr   <= take ? sel_addr  : '0;
      o_mem_wdata  <= take ? sel_wdata : '0;
      o_rsp_valid0 <= (state == ACCESS) && (lat_port == 1'b0);
      o_rsp_valid1 <= (state == ACCESS) && (lat_port == 1'b1);
      o_rsp_err    <= (state == ACCESS) && !lat_ok;
      o_rsp_rdata  <= ((state == ACCESS) && lat_ok && !lat_we) ? i_mem_rdata : '0;
      o_busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Scoreboard bench for mem_data_arbiter with a transaction-level model and a memory model.
// Arbitration expectations follow MEMARB_RR_EN when defined, fixed priority otherwise.
module tb_mem_data_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req0, i_req1, i_we0, i_we1;
  logic [31:0] i_addr0, i_addr1, i_wdata0, i_wdata1;
  logic        o_gnt0, o_gnt1, o_rsp_valid0, o_rsp_valid1, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic        o_mem_write, o_mem_read;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic        o_busy;

  mem_data_arbiter dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req0       (i_req0),
    .i_req1       (i_req1),
    .i_we0        (i_we0),
    .i_we1        (i_we1),
    .i_addr0      (i_addr0),
    .i_addr1      (i_addr1),
    .i_wdata0     (i_wdata0),
    .i_wdata1     (i_wdata1),
    .o_gnt0       (o_gnt0),
    .o_gnt1       (o_gnt1),
    .o_rsp_valid0 (o_rsp_valid0),
    .o_rsp_valid1 (o_rsp_valid1),
    .o_rsp_err    (o_rsp_err),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_mem_write  (o_mem_write),
    .o_mem_read   (o_mem_read),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Memory: out-of-window addresses return a nonzero pattern that must never reach a response.
  logic [31:0] mem [256];
  assign i_mem_rdata = (o_mem_addr >= 32'hC00 && o_mem_addr <= 32'hCFF) ?
                       mem[o_mem_addr[7:0]] : (32'hA5A5_0000 ^ o_mem_addr);
  always @(posedge i_clk) begin
    if (o_mem_write) mem[o_mem_addr[7:0]] <= o_mem_wdata;
  end

  typedef struct packed {
    logic        v0;
    logic        v1;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] model_mem [logic [31:0]];
  int          cooldown;
  logic        last_port;
  logic        cur_we, cur_ok;
  logic [31:0] cur_addr, cur_wdata;
  int          checks_total = 0;
  int          checks_passed = 0;

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference model: one transaction occupies the grant cycle plus two busy cycles.
  initial begin : model
    rsp_t        e;
    logic        r0, r1, w, eg0, eg1;
    logic [31:0] a, d;
    cooldown  = 0;
    last_port = 1'b1;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        checkOutput("reset_flags",
                    {o_gnt0, o_gnt1, o_rsp_valid0, o_rsp_valid1, o_rsp_err, o_mem_write, o_mem_read, o_busy},
                    96'd0);
        checkOutput("reset_data", {o_rsp_rdata, o_mem_addr, o_mem_wdata}, 96'd0);
        rsp_q.delete();
        cooldown  = 0;
        last_port = 1'b1;
      end else begin
        checkOutput("busy", o_busy, cooldown > 0);
        if (cooldown == 2) begin
          if (cur_ok) begin
            checkOutput("mem_access", {o_mem_write, o_mem_read, o_mem_addr}, {cur_we, !cur_we, cur_addr});
            checkOutput("mem_wdata", o_mem_wdata, cur_wdata);
            if (cur_we) model_mem[cur_addr] = cur_wdata;
          end else begin
            checkOutput("mem_no_strobe", {o_mem_write, o_mem_read}, 2'b00);
          end
        end else begin
          checkOutput("mem_quiet", {o_mem_write, o_mem_read, o_mem_addr, o_mem_wdata}, 96'd0);
        end
        if (o_rsp_valid0 || o_rsp_valid1) begin
          if (rsp_q.size() == 0) begin
            checkOutput("rsp_unexpected", {o_rsp_valid0, o_rsp_valid1}, 2'b00);
          end else begin
            e = rsp_q.pop_front();
            checkOutput("rsp", {o_rsp_valid0, o_rsp_valid1, o_rsp_err, o_rsp_rdata}, e);
          end
        end else if (cooldown == 1 && rsp_q.size() > 0) begin
          e = rsp_q.pop_front();
          checkOutput("rsp_missing", {o_rsp_valid0, o_rsp_valid1, o_rsp_err, o_rsp_rdata}, e);
        end else begin
          checkOutput("rsp_quiet", {o_rsp_err, o_rsp_rdata}, 33'd0);
        end
        r0 = i_req0; r1 = i_req1; eg0 = 1'b0; eg1 = 1'b0;
        if (cooldown > 0) begin
          cooldown--;
        end else if (r0 || r1) begin
          if (r0 && r1) begin
`ifdef MEMARB_RR_EN
            w = !last_port;
`else
            w = 1'b0;
`endif
          end else begin
            w = r1;
          end
          last_port = w;
          cur_we    = w ? i_we1 : i_we0;
          a         = w ? i_addr1 : i_addr0;
          d         = w ? i_wdata1 : i_wdata0;
          cur_addr  = a;
          cur_wdata = d;
          cur_ok    = (a >= 32'hC00) && (a <= 32'hCFF);
          e.v0      = !w;
          e.v1      = w;
          e.err     = !cur_ok;
          e.rdata   = (!cur_we && cur_ok && model_mem.exists(a)) ? model_mem[a] : 32'd0;
          rsp_q.push_back(e);
          cooldown  = 2;
          eg0 = !w;
          eg1 = w;
        end
        checkOutput("gnt", {o_gnt0, o_gnt1}, {eg0, eg1});
      end
    end
  end

  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic got = 1'b0;
    @(posedge i_clk); #1;
    if (port == 1'b0) begin
      i_req0 = 1'b1; i_we0 = we; i_addr0 = addr; i_wdata0 = wdata;
    end else begin
      i_req1 = 1'b1; i_we1 = we; i_addr1 = addr; i_wdata1 = wdata;
    end
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge i_clk);
      got = (port == 1'b0) ? o_gnt0 : o_gnt1;
    end
    if (!got) begin
      checks_total++;
      $display("[TB] FAIL grant_timeout port %0d: got no grant, expected grant within 40 cycles", port);
    end
    @(posedge i_clk); #1;
    if (port == 1'b0) i_req0 = 1'b0;
    else i_req1 = 1'b0;
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 5))
      0:       return 32'hC00;
      1:       return 32'hCFF;
      2:       return 32'hBFF;
      3:       return 32'hD00;
      4:       return 32'hC00 + 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic got;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    i_reset = 1'b1;
    i_req0 = 0; i_req1 = 0; i_we0 = 0; i_we1 = 0;
    i_addr0 = 0; i_addr1 = 0; i_wdata0 = 0; i_wdata1 = 0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;

    $display("[TB] write/read-back");
    applyStimulus(1'b0, 1'b1, 32'hC10, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'hC10, 32'h0);

    $display("[TB] contention");
    fork
      begin
        applyStimulus(1'b0, 1'b1, 32'hC01, 32'h1111_0001);
        applyStimulus(1'b0, 1'b1, 32'hC02, 32'h1111_0002);
      end
      begin
        applyStimulus(1'b1, 1'b1, 32'hC03, 32'h2222_0003);
        applyStimulus(1'b1, 1'b0, 32'hC01, 32'h0);
      end
    join

    $display("[TB] out of range and boundaries");
    applyStimulus(1'b1, 1'b0, 32'hD00, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hC00, 32'hC000_0001);
    applyStimulus(1'b1, 1'b1, 32'hCFF, 32'hCFF0_0002);
    applyStimulus(1'b0, 1'b1, 32'hBFF, 32'hBAD0_0003);
    applyStimulus(1'b0, 1'b0, 32'hC00, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'hCFF, 32'h0);

    $display("[TB] reset during write access");
    @(posedge i_clk); #1;
    i_req0 = 1'b1; i_we0 = 1'b1; i_addr0 = 32'hC20; i_wdata0 = 32'h5555_AAAA;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge i_clk);
      got = o_gnt0;
    end
    if (!got) begin
      checks_total++;
      $display("[TB] FAIL grant_timeout reset test: got no grant, expected grant");
    end
    @(posedge i_clk); #1;
    i_req0 = 1'b0;
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'hC20, 32'h0);

    $display("[TB] port 0 waits across a port 1 transaction");
    fork
      applyStimulus(1'b1, 1'b1, 32'hC30, 32'h3030_3030);
      begin
        @(posedge i_clk);
        applyStimulus(1'b0, 1'b0, 32'hC30, 32'h0);
      end
    join

    $display("[TB] randomized traffic");
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: applyStimulus(1'b0, 1'($urandom_range(0, 1)), randAddr(), $urandom);
        1: applyStimulus(1'b1, 1'($urandom_range(0, 1)), randAddr(), $urandom);
        default: fork
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), randAddr(), $urandom);
          applyStimulus(1'b1, 1'($urandom_range(0, 1)), randAddr(), $urandom);
        join
      endcase
    end

    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rsp_drained", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mem_data_arbiter.md
# mem_data_arbiter

Two-port arbiter and sequencer for the shared data memory (word-indexed window 0xC00–0xCFF, combinational read, write on i_clk rising edge). Port 0 serves the core load/store stage, port 1 serves the debug/DMA master. The block accepts one request at a time, checks its address range, and drives the memory's write-enable, read-enable, address and write-data inputs for exactly one cycle. It registers the read data and returns a one-cycle response to the winning port.

## Interface
- ADDR_LO, 32'h0000_0C00, lowest valid word address
- ADDR_HI, 32'h0000_0CFF, highest valid word address (inclusive)
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_req0 / i_req1  in  1  request from port 0 / port 1
- i_we0 / i_we1  in  1  1 = write, 0 = read
- i_addr0 / i_addr1  in  32  word address
- i_wdata0 / i_wdata1  in  32  write data
- o_gnt0 / o_gnt1  out  1  one-cycle pulse: request accepted, payload latched
- o_rsp_valid0 / o_rsp_valid1  out  1  one-cycle response pulse
- o_rsp_err  out  1  valid with o_rsp_valid*: address out of range
- o_rsp_rdata  out  32  read data, valid with o_rsp_valid* on a good read; 0 otherwise
- o_mem_write  out  1  to memory write-enable
- o_mem_read  out  1  to memory read-enable
- o_mem_addr  out  32  to memory address
- o_mem_wdata  out  32  to memory write data
- i_mem_rdata  in  32  from memory read data
- o_busy  out  1  high when the block is not in IDLE

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - If any i_req is high, pick the winner, pulse its o_gnt, latch we/addr/wdata/port-id and the range flag (ADDR_LO ≤ addr ≤ ADDR_HI), then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - In range: o_mem_read or o_mem_write is high for this cycle only, with o_mem_addr and o_mem_wdata taken from the latch. The memory write commits at the closing edge, where i_mem_rdata is also captured for a read.
  - Out of range: no memory strobe is raised and the error flag is set.
  - Always goes to RESP.
- RESP:
  - The latched port gets o_rsp_valid for one cycle, with o_rsp_err and o_rsp_rdata.
  - Always goes to IDLE.
- Requester rules:
  - Hold i_req and the payload stable until o_gnt is seen.
  - Deassert i_req (or present the next request) in the cycle after o_gnt.
  - Must accept o_rsp_valid unconditionally; there is no ready signal.
- Requests arriving in ACCESS or RESP wait. They are evaluated in the next IDLE.
- Simultaneous requests in IDLE: see Configuration. The loser keeps waiting, with no starvation in RR mode.
- Write responses carry o_rsp_rdata = 0.
- Memory strobes are low in IDLE and RESP. o_mem_addr and o_mem_wdata are 0 outside ACCESS.
- Reset, at any time:
  - FSM goes to IDLE; every output goes to 0; the RR pointer is set so port 0 wins first.
  - An in-flight transaction is dropped with no response.
  - A write whose commit edge has not yet occurred is not performed.

## Timing
- Request → o_gnt: same cycle as IDLE sampling (combinational from i_req and FSM state).
- o_gnt → memory strobe: 1 cycle.
- Memory strobe → o_rsp_valid: 1 cycle.
- Back-to-back throughput: 1 transaction per 3 cycles.
- o_rsp_*, o_mem_*, o_busy are registered. o_gnt* is a combinational decode of the registered state.

## Configuration
- MEMARB_RR_EN defined: round-robin arbitration.
  - On contention, the port not granted last wins.
  - The pointer updates only on a grant.
- MEMARB_RR_EN undefined: fixed priority, port 0 always wins.
  - No pointer register exists.

## Structure
- Package memarb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP)
  - defaults for ADDR_LO and ADDR_HI
  - the port-id type (1 bit)
- Sub-module memarb_pick contains the winner selection: fixed priority or round-robin under MEMARB_RR_EN.
- The top level holds the FSM, latches and range check.

## Test plan
- Port 0 write 0xDEAD_BEEF to 0xC10 → o_gnt0 in cycle 0, o_mem_write=1 with o_mem_addr=0xC10 in cycle 1, o_rsp_valid0=1 with err=0 in cycle 2. A port 1 read of 0xC10 then returns 0xDEAD_BEEF.
- Both ports request in the same cycle, twice in succession → RR: port 0 then port 1 granted. Without MEMARB_RR_EN: port 0 both times, port 1 granted third.
- Port 1 read 0xD00 (out of range) → no o_mem_read or o_mem_write pulse; o_rsp_valid1=1, o_rsp_err=1, o_rsp_rdata=0.
- Boundary addresses 0xC00 and 0xCFF → accepted, err=0. Address 0xBFF → err=1.
- Assert i_reset during ACCESS of a write to 0xC20 → all outputs 0, no o_rsp_valid. After reset, a read of 0xC20 returns 0.
- Port 0 holds i_req across a port 1 transaction → port 0 is granted in the first IDLE after that transaction's RESP; o_busy goes low for exactly that IDLE cycle.
